// File: rtl/spi_buf_pkg.sv
// Shared definitions for the SPI command-buffer arbiter: command word layout
// and sequencer state encoding.
package spi_buf_pkg;

  localparam int BUF_W   = 41;
  localparam int ADR_MSB = 40;
  localparam int ADR_LSB = 33;
  localparam int DAT_MSB = 32;
  localparam int DAT_LSB = 1;
  localparam int WE_BIT  = 0;
  localparam int DAT_W   = DAT_MSB - DAT_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping N-1 -> 0. Returns one-hot and encoded winner.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    logic [IW-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_buf_arbiter.sv
// Shares the single SPI command buffer port between NREQ requesters:
// round-robin grant, one transaction at a time, ACK timeout with error flag.
module spi_buf_arbiter
  import spi_buf_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  WB_CLK_I,
  input  logic                  WB_RST_I,
  input  logic [NREQ-1:0]       REQ_STATUS,
  input  logic [BUF_W*NREQ-1:0] REQ_DATA_I,
  output logic [NREQ-1:0]       REQ_ACK,
  output logic                  REQ_ERR,
  output logic [DAT_W-1:0]      REQ_DATA_O,
  output logic [NREQ-1:0]       GRANT,
  output logic                  BUF_STATUS,
  output logic [BUF_W-1:0]      BUF_DATA_O,
  input  logic [BUF_W-1:0]      BUF_DATA_I,
  input  logic                  BUF_ACK,
  output logic [2:0]            STATE_DBG
);

  // Handshake: a requester holds REQ_STATUS until it sees its REQ_ACK pulse;
  // BUF_STATUS is held until BUF_ACK (a level) or timeout, and a new
  // transaction is not started until BUF_ACK has returned low.
  localparam int IW = $clog2(NREQ);
  localparam int CW = 16;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, owner_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            timeout_hit;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (REQ_STATUS),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign STATE_DBG   = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (BUF_ACK || timeout_hit) state_d = ST_RESP;
      ST_RESP:    state_d = ST_RELEASE;
      ST_RELEASE: if (!REQ_STATUS[owner_q] && !BUF_ACK) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge WB_CLK_I or negedge WB_RST_I) begin
    if (!WB_RST_I) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      REQ_ACK    <= '0;
      REQ_ERR    <= 1'b0;
      REQ_DATA_O <= '0;
      GRANT      <= '0;
      BUF_STATUS <= 1'b0;
      BUF_DATA_O <= '0;
    end else begin
      state_q <= state_d;
      REQ_ACK <= '0;
      REQ_ERR <= 1'b0;
      case (state_q)
        ST_IDLE: if (pick_any) begin
          GRANT      <= pick_gnt;
          owner_q    <= pick_idx;
          BUF_DATA_O <= REQ_DATA_I[BUF_W*pick_idx +: BUF_W];
          ptr_q      <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
        ST_ISSUE: begin
          BUF_STATUS <= 1'b1;
          cnt_q      <= '0;
        end
        // ACK is tested first so an ACK on the final cycle still wins.
        ST_WAIT: begin
          if (BUF_ACK) begin
            BUF_STATUS <= 1'b0;
            REQ_ACK    <= GRANT;
            REQ_DATA_O <= BUF_DATA_O[WE_BIT] ? '0 : BUF_DATA_I[DAT_MSB:DAT_LSB];
          end else if (timeout_hit) begin
            BUF_STATUS <= 1'b0;
            REQ_ACK    <= GRANT;
            REQ_ERR    <= 1'b1;
            REQ_DATA_O <= '0;
            err_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RELEASE: if (state_d == ST_IDLE) begin
          GRANT <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_buf_arbiter.sv
// Bench for spi_buf_arbiter (NREQ=2, TIMEOUT=8): directed transactions with a
// response scoreboard fed at issue time and drained on REQ_ACK pulses.
module tb_spi_buf_arbiter;
  import spi_buf_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 8;
  localparam int EW      = NREQ + 1 + 32;

  logic                  WB_CLK_I;
  logic                  WB_RST_I;
  logic [NREQ-1:0]       REQ_STATUS;
  logic [BUF_W*NREQ-1:0] REQ_DATA_I;
  logic [NREQ-1:0]       REQ_ACK;
  logic                  REQ_ERR;
  logic [31:0]           REQ_DATA_O;
  logic [NREQ-1:0]       GRANT;
  logic                  BUF_STATUS;
  logic [BUF_W-1:0]      BUF_DATA_O;
  logic [BUF_W-1:0]      BUF_DATA_I;
  logic                  BUF_ACK;
  logic [2:0]            STATE_DBG;

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_acks   = 0;
  logic [EW-1:0]    exp_q[$];
  logic [BUF_W-1:0] cmds[NREQ];

  spi_buf_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .WB_CLK_I   (WB_CLK_I),
    .WB_RST_I   (WB_RST_I),
    .REQ_STATUS (REQ_STATUS),
    .REQ_DATA_I (REQ_DATA_I),
    .REQ_ACK    (REQ_ACK),
    .REQ_ERR    (REQ_ERR),
    .REQ_DATA_O (REQ_DATA_O),
    .GRANT      (GRANT),
    .BUF_STATUS (BUF_STATUS),
    .BUF_DATA_O (BUF_DATA_O),
    .BUF_DATA_I (BUF_DATA_I),
    .BUF_ACK    (BUF_ACK),
    .STATE_DBG  (STATE_DBG)
  );

  // clock / watchdog
  initial WB_CLK_I = 1'b0;
  always #5 WB_CLK_I = ~WB_CLK_I;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every REQ_ACK cycle must match the next queued response
  always @(negedge WB_CLK_I) begin
    if (|REQ_ACK) begin
      n_acks++;
      if (exp_q.size() == 0) check("spurious_ack", {REQ_ACK, REQ_ERR, REQ_DATA_O}, '0);
      else check("resp", {REQ_ACK, REQ_ERR, REQ_DATA_O}, exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge WB_CLK_I);
    #1;
  endtask

  task automatic start_req(input int who, input logic [BUF_W-1:0] cmd);
    REQ_DATA_I[BUF_W*who +: BUF_W] = cmd;
    REQ_STATUS[who] = 1'b1;
  endtask

  // Runs one granted transaction; ack_delay < 0 means the buffer never acks,
  // followed by a late ACK pulse while the grant is still held.
  task automatic run_txn(input int who, input logic [BUF_W-1:0] cmd,
                         input int ack_delay, input logic [31:0] rdata);
    logic [NREQ-1:0] av;
    logic            exp_err;
    logic [31:0]     exp_dat;
    int              n;
    int              exp_n;
    av      = NREQ'(1 << who);
    exp_err = (ack_delay < 0);
    exp_dat = (exp_err || cmd[WE_BIT]) ? 32'h0 : rdata;
    exp_n   = (ack_delay < 0 || ack_delay + 1 > TIMEOUT) ? TIMEOUT : ack_delay + 1;
    tick();
    check("grant", GRANT, av);
    check("buf_data_o", BUF_DATA_O, cmd);
    check("buf_status_early", BUF_STATUS, 0);
    exp_q.push_back({av, exp_err, exp_dat});
    n_pushed++;
    tick();
    check("buf_status_rise", BUF_STATUS, 1);
    n = 0;
    if (ack_delay >= 0) begin
      repeat (ack_delay) tick();
      n = ack_delay;
      BUF_DATA_I = {8'h00, rdata, 1'b0};
      BUF_ACK    = 1'b1;
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      n++;
      if (!BUF_STATUS) break;
    end
    check("wait_len", n, exp_n);
    BUF_ACK = 1'b0;
    if (ack_delay < 0) begin
      repeat (3) tick();
      BUF_ACK = 1'b1;
      tick();
      BUF_ACK = 1'b0;
      tick();
      check("late_ack_held_grant", GRANT, av);
    end
    REQ_STATUS[who] = 1'b0;
    for (int k = 0; k < 20 && GRANT != '0; k++) tick();
    check("grant_clear", GRANT, 0);
  endtask

  initial begin
    WB_RST_I   = 1'b0;
    REQ_STATUS = '0;
    REQ_DATA_I = '0;
    BUF_DATA_I = '0;
    BUF_ACK    = 1'b0;
    repeat (3) tick();
    check("rst_grant", GRANT, 0);
    check("rst_buf_status", BUF_STATUS, 0);
    check("rst_buf_data", BUF_DATA_O, 0);
    check("rst_ack", {REQ_ACK, REQ_ERR, REQ_DATA_O}, 0);
    check("rst_state", STATE_DBG, ST_IDLE);
    WB_RST_I = 1'b1;
    tick();

    // single write from requester 0, ack after 5 cycles
    start_req(0, {8'h12, 32'hDEADBEEF, 1'b1});
    run_txn(0, {8'h12, 32'hDEADBEEF, 1'b1}, 5, 32'h1234_5678);

    // single read from requester 1
    start_req(1, {8'h40, 32'h0, 1'b0});
    run_txn(1, {8'h40, 32'h0, 1'b0}, 2, 32'hCAFEF00D);

    // contention: both held, grants must alternate 0,1,0,1
    cmds[0] = {8'h20, 32'($urandom()), 1'b1};
    cmds[1] = {8'h21, 32'($urandom()), 1'b0};
    REQ_DATA_I = {cmds[1], cmds[0]};
    REQ_STATUS = 2'b11;
    for (int t = 0; t < 4; t++) begin
      run_txn(t % 2, cmds[t % 2], int'($urandom_range(0, 4)), 32'($urandom()));
      if (t < 3) begin
        cmds[t % 2] = {8'(8'h30 + t), 32'($urandom()), 1'($urandom_range(0, 1))};
        start_req(t % 2, cmds[t % 2]);
      end
    end
    REQ_STATUS = '0;
    tick();
    check("idle_after_contention", STATE_DBG, ST_IDLE);

    // timeout on a read with stale nonzero buffer data
    BUF_DATA_I = {8'h00, 32'h5555AAAA, 1'b0};
    start_req(0, {8'h55, 32'h0, 1'b0});
    run_txn(0, {8'h55, 32'h0, 1'b0}, -1, 32'h0);

    // ACK on the final counted cycle wins over timeout
    start_req(1, {8'h66, 32'h0, 1'b0});
    run_txn(1, {8'h66, 32'h0, 1'b0}, TIMEOUT - 1, 32'hA5A5_0F0F);

    // reset asserted mid-WAIT from requester 0 (pointer then at 1)
    start_req(0, {8'h77, 32'h0, 1'b0});
    repeat (5) tick();
    check("pre_rst_state", STATE_DBG, ST_WAIT);
    WB_RST_I = 1'b0;
    #1;
    check("midrst_buf_status", BUF_STATUS, 0);
    check("midrst_grant", GRANT, 0);
    check("midrst_ack", REQ_ACK, 0);
    REQ_STATUS = '0;
    repeat (2) tick();
    WB_RST_I = 1'b1;
    tick();

    // both pending after reset: pointer back to 0
    cmds[0] = {8'h80, 32'h0, 1'b0};
    cmds[1] = {8'h81, 32'h0BAD_F00D, 1'b1};
    REQ_DATA_I = {cmds[1], cmds[0]};
    REQ_STATUS = 2'b11;
    run_txn(0, cmds[0], 1, 32'h1357_9BDF);
    run_txn(1, cmds[1], 3, 32'h2468_ACE0);

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);
    check("ack_count", n_acks, n_pushed);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
